// File: rtl/issue_sort.sv
// issue_sort: in-order dispatch stage between rename and the reservation stations.
// Each cycle it scans up to FETCH_WIDTH renamed ops oldest-first, retires NOPs
// without a slot, and steers ALU/MEM/TERM ops into registered per-class slots.
// After loading a terminator it holds dispatch until the back end resolves it.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flush               drop all slot contents and any terminator wait
//   i_instr_in/_valid     fetch group, lane 0 oldest
//   o_instr_used          combinational per-lane consume mask
//   o_alu_*/i_alu_ready   ALU slots, valid/ready per slot
//   o_mem_*/i_mem_ready   memory slots, valid/ready per slot
//   o_term_*/i_term_ready terminator slot
//   i_term_resolved       pulse ending the terminator wait
//   o_waiting             high while waiting for a terminator to resolve

`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 64
`endif

module issue_sort #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned ALU_PORTS   = 2,
  parameter int unsigned MEM_PORTS   = 1
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_flush,
  input  logic [FETCH_WIDTH*`RENAMED_OP_SZ-1:0] i_instr_in,
  input  logic [FETCH_WIDTH-1:0]                i_instr_valid,
  output logic [FETCH_WIDTH-1:0]                o_instr_used,
  output logic [ALU_PORTS*`RENAMED_OP_SZ-1:0]   o_alu_out,
  output logic [ALU_PORTS-1:0]                  o_alu_valid,
  input  logic [ALU_PORTS-1:0]                  i_alu_ready,
  output logic [MEM_PORTS*`RENAMED_OP_SZ-1:0]   o_mem_out,
  output logic [MEM_PORTS-1:0]                  o_mem_valid,
  input  logic [MEM_PORTS-1:0]                  i_mem_ready,
  output logic [`RENAMED_OP_SZ-1:0]             o_term_out,
  output logic                                  o_term_valid,
  input  logic                                  i_term_ready,
  input  logic                                  i_term_resolved,
  output logic                                  o_waiting
);

  localparam int unsigned OpW = `RENAMED_OP_SZ;

  typedef enum logic [0:0] {StRun, StWaitTerm} state_e;

  state_e r_state;
  state_e w_state_next;

  logic [ALU_PORTS-1:0][OpW-1:0] r_alu_data;
  logic [ALU_PORTS-1:0]          r_alu_valid;
  logic [MEM_PORTS-1:0][OpW-1:0] r_mem_data;
  logic [MEM_PORTS-1:0]          r_mem_valid;
  logic [OpW-1:0]                r_term_data;
  logic                          r_term_valid;

  logic [ALU_PORTS-1:0]          w_alu_free;
  logic [MEM_PORTS-1:0]          w_mem_free;
  logic                          w_term_free;
  logic [ALU_PORTS-1:0]          w_alu_load;
  logic [ALU_PORTS-1:0][OpW-1:0] w_alu_load_data;
  logic [MEM_PORTS-1:0]          w_mem_load;
  logic [MEM_PORTS-1:0][OpW-1:0] w_mem_load_data;
  logic                          w_term_load;
  logic [OpW-1:0]                w_term_load_data;
  logic [FETCH_WIDTH-1:0]        w_used;
  logic                          w_scan_en;

  // A slot can accept a new op when empty or when its current op leaves this cycle.
  assign w_alu_free  = ~r_alu_valid | i_alu_ready;
  assign w_mem_free  = ~r_mem_valid | i_mem_ready;
  assign w_term_free = ~r_term_valid | i_term_ready;

  // In-order scan: each lane claims the lowest still-available slot of its class.
  always_comb begin : scan
    logic [ALU_PORTS-1:0] alu_avail;
    logic [MEM_PORTS-1:0] mem_avail;
    logic                 stop;
    logic                 found;
    logic [OpW-1:0]       op;
    logic [3:0]           opc;

    w_used           = '0;
    w_alu_load       = '0;
    w_alu_load_data  = '0;
    w_mem_load       = '0;
    w_mem_load_data  = '0;
    w_term_load      = 1'b0;
    w_term_load_data = '0;
    alu_avail        = w_alu_free;
    mem_avail        = w_mem_free;
    stop             = ~w_scan_en;
    found            = 1'b0;
    op               = '0;
    opc              = '0;

    for (int i = 0; i < FETCH_WIDTH; i++) begin
      op    = i_instr_in[i*OpW +: OpW];
      opc   = op[47:44];
      found = 1'b0;
      if (!stop) begin
        if (!i_instr_valid[i]) begin
          stop = 1'b1;
        end else if (opc[3:2] != 2'b11) begin
          if (op[55:48] == 8'h00) begin
            w_used[i] = 1'b1;  // NOP retires without a slot
          end else begin
            for (int j = 0; j < ALU_PORTS; j++) begin
              if (!found && alu_avail[j]) begin
                found              = 1'b1;
                alu_avail[j]       = 1'b0;
                w_alu_load[j]      = 1'b1;
                w_alu_load_data[j] = op;
              end
            end
            w_used[i] = found;
            stop      = ~found;
          end
        end else if (opc[3:1] == 3'b110) begin
          for (int j = 0; j < MEM_PORTS; j++) begin
            if (!found && mem_avail[j]) begin
              found              = 1'b1;
              mem_avail[j]       = 1'b0;
              w_mem_load[j]      = 1'b1;
              w_mem_load_data[j] = op;
            end
          end
          w_used[i] = found;
          stop      = ~found;
        end else begin
          // Terminator: younger lanes always wait for resolution.
          if (w_term_free) begin
            w_used[i]        = 1'b1;
            w_term_load      = 1'b1;
            w_term_load_data = op;
          end
          stop = 1'b1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = StRun;
    end else begin
      unique case (r_state)
        StRun:      if (w_term_load) w_state_next = StWaitTerm;
        StWaitTerm: if (i_term_resolved) w_state_next = StRun;
        default:    w_state_next = StRun;
      endcase
    end
  end

  // Output logic
  always_comb begin
    w_scan_en    = (r_state == StRun) && !i_flush && !i_rst;
    o_waiting    = (r_state == StWaitTerm);
    o_instr_used = w_used;
  end

  // Slot registers: load wins over drain so a slot can transfer and refill together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_alu_valid  <= '0;
      r_alu_data   <= '0;
      r_mem_valid  <= '0;
      r_mem_data   <= '0;
      r_term_valid <= 1'b0;
      r_term_data  <= '0;
    end else if (i_flush) begin
      r_alu_valid  <= '0;
      r_mem_valid  <= '0;
      r_term_valid <= 1'b0;
    end else begin
      for (int j = 0; j < ALU_PORTS; j++) begin
        if (w_alu_load[j]) begin
          r_alu_valid[j] <= 1'b1;
          r_alu_data[j]  <= w_alu_load_data[j];
        end else if (i_alu_ready[j]) begin
          r_alu_valid[j] <= 1'b0;
        end
      end
      for (int j = 0; j < MEM_PORTS; j++) begin
        if (w_mem_load[j]) begin
          r_mem_valid[j] <= 1'b1;
          r_mem_data[j]  <= w_mem_load_data[j];
        end else if (i_mem_ready[j]) begin
          r_mem_valid[j] <= 1'b0;
        end
      end
      if (w_term_load) begin
        r_term_valid <= 1'b1;
        r_term_data  <= w_term_load_data;
      end else if (i_term_ready) begin
        r_term_valid <= 1'b0;
      end
    end
  end

  assign o_alu_out    = r_alu_data;
  assign o_alu_valid  = r_alu_valid;
  assign o_mem_out    = r_mem_data;
  assign o_mem_valid  = r_mem_valid;
  assign o_term_out   = r_term_data;
  assign o_term_valid = r_term_valid;

endmodule

// File: tb/tb_issue_sort.sv
// tb_issue_sort: randomized and directed stimulus for issue_sort with a
// class-level reference model; slot contents are checked by a scoreboard
// monitor whenever a slot hands an op to its sink.

`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 64
`endif

module tb_issue_sort;

  localparam int OPW = `RENAMED_OP_SZ;
  localparam int FW  = 4;
  localparam int AP  = 2;
  localparam int MP  = 1;

  localparam int CAlu  = 0;
  localparam int CMem  = 1;
  localparam int CTerm = 2;
  localparam int CNop  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [FW*OPW-1:0] instr_in;
  logic [FW-1:0]     instr_valid;
  logic [FW-1:0]     instr_used;
  logic [AP*OPW-1:0] alu_out;
  logic [AP-1:0]     alu_valid;
  logic [AP-1:0]     alu_ready;
  logic [MP*OPW-1:0] mem_out;
  logic [MP-1:0]     mem_valid;
  logic [MP-1:0]     mem_ready;
  logic [OPW-1:0]    term_out;
  logic              term_valid;
  logic              term_ready;
  logic              term_resolved;
  logic              waiting;

  always #5 clk = ~clk;

  issue_sort #(
    .FETCH_WIDTH(FW),
    .ALU_PORTS  (AP),
    .MEM_PORTS  (MP)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .i_instr_in     (instr_in),
    .i_instr_valid  (instr_valid),
    .o_instr_used   (instr_used),
    .o_alu_out      (alu_out),
    .o_alu_valid    (alu_valid),
    .i_alu_ready    (alu_ready),
    .o_mem_out      (mem_out),
    .o_mem_valid    (mem_valid),
    .i_mem_ready    (mem_ready),
    .o_term_out     (term_out),
    .o_term_valid   (term_valid),
    .i_term_ready   (term_ready),
    .i_term_resolved(term_resolved),
    .o_waiting      (waiting)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Staged stimulus for the next cycle
  logic           s_rst, s_flush, s_res, s_term_rdy;
  logic [FW-1:0]  s_valid;
  logic [AP-1:0]  s_alu_rdy;
  logic [MP-1:0]  s_mem_rdy;
  logic [OPW-1:0] s_lane [FW];

  // Reference model: occupancy of each slot and whether a terminator is pending
  logic [AP-1:0]  m_alu_v;
  logic [MP-1:0]  m_mem_v;
  logic           m_term_v;
  logic           m_wait;

  // Expected contents of each slot, in load order
  logic [OPW-1:0] q_alu0 [$];
  logic [OPW-1:0] q_alu1 [$];
  logic [OPW-1:0] q_mem  [$];
  logic [OPW-1:0] q_term [$];

  logic [FW-1:0]  got_used;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int cls(input logic [OPW-1:0] op);
    logic [3:0] opc;
    opc = op[47:44];
    if (opc[3:1] == 3'b111) return CTerm;
    if (opc[3:1] == 3'b110) return CMem;
    if (op[55:48] == 8'h00) return CNop;
    return CAlu;
  endfunction

  function automatic logic [OPW-1:0] rand_op(input int c);
    logic [OPW-1:0] op;
    logic [1:0]     hi;
    op = OPW'({$urandom, $urandom});
    hi = 2'($urandom_range(0, 2));
    case (c)
      CAlu: begin op[47:46] = hi; op[55:48] = 8'($urandom_range(1, 255)); end
      CNop: begin op[47:46] = hi; op[55:48] = 8'h00; end
      CMem: op[47:45] = 3'b110;
      default: op[47:45] = 3'b111;
    endcase
    return op;
  endfunction

  function automatic int rand_cls();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 40) return CAlu;
    if (r < 55) return CNop;
    if (r < 85) return CMem;
    return CTerm;
  endfunction

  task automatic set_lanes(input int c0, input int c1, input int c2, input int c3);
    s_lane[0] = rand_op(c0);
    s_lane[1] = rand_op(c1);
    s_lane[2] = rand_op(c2);
    s_lane[3] = rand_op(c3);
    s_valid   = 4'b1111;
  endtask

  task automatic set_ready(input logic [AP-1:0] a, input logic m, input logic t);
    s_alu_rdy  = a;
    s_mem_rdy  = m;
    s_term_rdy = t;
  endtask

  // One clock cycle: drive, predict and check the consume mask, then check the
  // registered state after the edge and record what each slot now holds.
  task automatic tick();
    logic [FW-1:0]  exp_used;
    logic [AP-1:0]  ld_alu;
    logic [OPW-1:0] ld_alu_d [AP];
    logic           ld_mem, ld_term, hit_term, clear;
    logic [OPW-1:0] ld_mem_d, ld_term_d;
    int             alu_fq[$];
    logic           mem_free, term_free;
    int             c, k;

    rst           = s_rst;
    flush         = s_flush;
    instr_valid   = s_valid;
    for (int i = 0; i < FW; i++) instr_in[i*OPW +: OPW] = s_lane[i];
    alu_ready     = s_alu_rdy;
    mem_ready     = s_mem_rdy;
    term_ready    = s_term_rdy;
    term_resolved = s_res;
    #1;

    exp_used = '0; ld_alu = '0; ld_mem = 1'b0; ld_term = 1'b0; hit_term = 1'b0;
    ld_mem_d = '0; ld_term_d = '0;
    for (int j = 0; j < AP; j++) ld_alu_d[j] = '0;
    if (!s_rst && !s_flush && !m_wait) begin
      for (int j = 0; j < AP; j++) if (!m_alu_v[j] || s_alu_rdy[j]) alu_fq.push_back(j);
      mem_free  = !m_mem_v[0] || s_mem_rdy[0];
      term_free = !m_term_v || s_term_rdy;
      for (int i = 0; i < FW; i++) begin
        if (!s_valid[i]) break;
        c = cls(s_lane[i]);
        if (c == CNop) begin
          exp_used[i] = 1'b1;
        end else if (c == CAlu) begin
          if (alu_fq.size() == 0) break;
          k = alu_fq.pop_front();
          ld_alu[k] = 1'b1;
          ld_alu_d[k] = s_lane[i];
          exp_used[i] = 1'b1;
        end else if (c == CMem) begin
          if (!mem_free) break;
          mem_free = 1'b0;
          ld_mem = 1'b1;
          ld_mem_d = s_lane[i];
          exp_used[i] = 1'b1;
        end else begin
          if (!term_free) break;
          ld_term = 1'b1;
          ld_term_d = s_lane[i];
          hit_term = 1'b1;
          exp_used[i] = 1'b1;
          break;
        end
      end
    end
    got_used = instr_used;
    chk("instr_used", 64'(instr_used), 64'(exp_used));

    clear = s_rst || s_flush;
    if (clear) begin
      m_alu_v = '0; m_mem_v = '0; m_term_v = 1'b0; m_wait = 1'b0;
    end else begin
      for (int j = 0; j < AP; j++) m_alu_v[j] = ld_alu[j] || (m_alu_v[j] && !s_alu_rdy[j]);
      m_mem_v[0] = ld_mem || (m_mem_v[0] && !s_mem_rdy[0]);
      m_term_v   = ld_term || (m_term_v && !s_term_rdy);
      if (hit_term) m_wait = 1'b1;
      else if (m_wait && s_res) m_wait = 1'b0;
    end

    @(posedge clk);
    #1;
    chk("alu_valid", 64'(alu_valid), 64'(m_alu_v));
    chk("mem_valid", 64'(mem_valid), 64'(m_mem_v));
    chk("term_valid", 64'(term_valid), 64'(m_term_v));
    chk("waiting", 64'(waiting), 64'(m_wait));
    if (clear) begin
      q_alu0.delete(); q_alu1.delete(); q_mem.delete(); q_term.delete();
    end
    if (ld_alu[0]) q_alu0.push_back(ld_alu_d[0]);
    if (ld_alu[1]) q_alu1.push_back(ld_alu_d[1]);
    if (ld_mem)    q_mem.push_back(ld_mem_d);
    if (ld_term)   q_term.push_back(ld_term_d);
  endtask

  task automatic drain();
    s_valid = '0; s_res = 1'b0; s_flush = 1'b0; s_rst = 1'b0;
    set_ready('1, 1'b1, 1'b1);
    tick();
    tick();
  endtask

  // Scoreboard monitor: every handoff to a sink must carry the oldest expected op.
  task automatic pop_cmp(input string name, input logic [OPW-1:0] got, inout logic [OPW-1:0] q[$]);
    logic [OPW-1:0] e;
    n_checks++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected transfer of %0h, expected none", name, got);
    end else begin
      e = q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, got, e, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (alu_valid[0] && alu_ready[0]) pop_cmp("alu0_data", alu_out[0 +: OPW], q_alu0);
      if (alu_valid[1] && alu_ready[1]) pop_cmp("alu1_data", alu_out[OPW +: OPW], q_alu1);
      if (mem_valid[0] && mem_ready[0]) pop_cmp("mem_data", mem_out[0 +: OPW], q_mem);
      if (term_valid && term_ready)     pop_cmp("term_data", term_out, q_term);
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; instr_in = '0; instr_valid = '0;
    alu_ready = '0; mem_ready = '0; term_ready = 1'b0; term_resolved = 1'b0;
    m_alu_v = '0; m_mem_v = '0; m_term_v = 1'b0; m_wait = 1'b0;
    s_rst = 1'b1; s_flush = 1'b0; s_res = 1'b0; s_valid = '1;
    set_lanes(CAlu, CAlu, CAlu, CAlu);
    set_ready('1, 1'b1, 1'b1);
    @(posedge clk);
    #1;

    // Reset with valid lanes: nothing consumed, outputs cleared
    tick();
    tick();
    chk("rst_used", 64'(got_used), 64'h0);
    chk("rst_alu_out_lo", alu_out[63:0], 64'h0);
    chk("rst_alu_out_hi", alu_out[127:64], 64'h0);
    chk("rst_term_out", 64'(term_out), 64'h0);
    s_rst = 1'b0;

    // {ALU, MEM, ALU, ALU}: two ALU slots and one MEM slot fill
    set_lanes(CAlu, CMem, CAlu, CAlu);
    tick();
    chk("amaa_used", 64'(got_used), 64'b0111);
    chk("amaa_alu_valid", 64'(alu_valid), 64'b11);
    chk("amaa_mem_valid", 64'(mem_valid), 64'b1);
    chk("amaa_alu0", alu_out[63:0], 64'(s_lane[0]));
    chk("amaa_alu1", alu_out[127:64], 64'(s_lane[2]));
    drain();

    // {NOP, NOP, MEM, TERM}: all consumed, then wait; resolve and resume
    set_lanes(CNop, CNop, CMem, CTerm);
    tick();
    chk("nnmt_used", 64'(got_used), 64'b1111);
    chk("nnmt_waiting", 64'(waiting), 64'b1);
    chk("nnmt_term_valid", 64'(term_valid), 64'b1);
    set_lanes(CAlu, CAlu, CAlu, CAlu);
    s_res = 1'b1;
    tick();
    chk("resolve_cycle_used", 64'(got_used), 64'h0);
    s_res = 1'b0;
    tick();
    chk("resume_used_nonzero", 64'(got_used != 0), 64'h1);
    drain();

    // MEM slot stalled by its sink blocks the group; releasing it lets two lanes go
    set_lanes(CMem, CAlu, CAlu, CAlu);
    s_valid = 4'b0111;
    set_ready(2'b00, 1'b0, 1'b0);
    tick();
    s_valid = 4'b1111;
    set_ready(2'b01, 1'b0, 1'b1);
    tick();
    chk("mem_stall_used", 64'(got_used), 64'h0);
    set_ready(2'b01, 1'b1, 1'b1);
    tick();
    chk("mem_release_used", 64'(got_used), 64'b0011);
    drain();

    // {ALU, TERM, ALU, ALU}: younger lanes held through the wait
    set_lanes(CAlu, CTerm, CAlu, CAlu);
    tick();
    chk("atAA_used", 64'(got_used), 64'b0011);
    tick();
    chk("wait_used_1", 64'(got_used), 64'h0);
    tick();
    chk("wait_used_2", 64'(got_used), 64'h0);
    // Flush during the wait returns to dispatch
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    chk("flush_wait_waiting", 64'(waiting), 64'h0);
    chk("flush_wait_term_valid", 64'(term_valid), 64'h0);
    drain();

    // Fill every slot, then flush (and then reset) with sinks stalled
    for (int pass = 0; pass < 2; pass++) begin
      set_lanes(CAlu, CAlu, CMem, CTerm);
      set_ready(2'b00, 1'b0, 1'b0);
      tick();
      chk("fill_used", 64'(got_used), 64'b1111);
      if (pass == 0) s_flush = 1'b1;
      else s_rst = 1'b1;
      tick();
      chk("clear_used", 64'(got_used), 64'h0);
      chk("clear_valids", 64'({alu_valid, mem_valid, term_valid}), 64'h0);
      chk("clear_waiting", 64'(waiting), 64'h0);
      s_flush = 1'b0;
      s_rst = 1'b0;
    end
    drain();

    // Lane 1 invalid stops the scan after lane 0
    set_lanes(CAlu, CAlu, CAlu, CAlu);
    s_valid = 4'b1101;
    tick();
    chk("gap_used", 64'(got_used), 64'b0001);
    drain();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      s_rst   = ($urandom_range(0, 299) == 0);
      s_flush = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < FW; i++) begin
        s_lane[i]  = rand_op(rand_cls());
        s_valid[i] = ($urandom_range(0, 9) < 8);
      end
      for (int j = 0; j < AP; j++) s_alu_rdy[j] = ($urandom_range(0, 9) < 7);
      s_mem_rdy  = ($urandom_range(0, 9) < 6);
      s_term_rdy = ($urandom_range(0, 9) < 7);
      s_res      = m_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_sort.md
# issue_sort

Parametrised in-order dispatch stage between rename and the per-class reservation stations. Each cycle it takes up to FETCH_WIDTH renamed ops and steers them by class into registered output slots: ALU_PORTS ALU slots, MEM_PORTS memory slots and one terminator slot. It consumes a contiguous oldest-first prefix of the fetch group, retires NOPs without using a slot, and holds dispatch after each terminator until the back end resolves it. Flush support and per-slot valid/ready handshakes are new relative to the earlier single-issue sorter.

## Interface
- FETCH_WIDTH, 4, lanes presented per cycle; lane 0 is oldest.
- ALU_PORTS, 2, ALU output slots.
- MEM_PORTS, 1, memory output slots.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all slot contents and any terminator wait.
- instr_in  in  FETCH_WIDTH*`RENAMED_OP_SZ  renamed ops, lane i at bits [i*`RENAMED_OP_SZ +: `RENAMED_OP_SZ].
- instr_valid  in  FETCH_WIDTH  per-lane valid.
- instr_used  out  FETCH_WIDTH  combinational; lane consumed this cycle.
- alu_out  out  ALU_PORTS*`RENAMED_OP_SZ  ALU slot contents.
- alu_valid  out  ALU_PORTS  per-slot valid.
- alu_ready  in  ALU_PORTS  per-slot sink ready.
- mem_out / mem_valid / mem_ready  out/out/in  MEM_PORTS*`RENAMED_OP_SZ / MEM_PORTS / MEM_PORTS  memory slots, same handshake.
- term_out / term_valid / term_ready  out/out/in  `RENAMED_OP_SZ / 1 / 1  terminator slot.
- term_resolved  in  1  one-cycle pulse: outstanding terminator resolved.
- waiting  out  1  registered; high while in WAIT_TERM.

## Operation
- Decode per lane, with opcode = op[47:44]:
  - ALU: opcode[3:2] != 2'b11.
  - MEM: opcode[3:1] == 3'b110.
  - TERM: opcode[3:1] == 3'b111.
  - NOP: ALU with op[55:48] == 8'h00.
- Slot free this cycle when !valid or (valid & ready). A transfer happens when valid & ready.
- In-order scan from lane 0. Each lane is consumed only if every older lane was consumed this cycle. The scan stops at the first lane that is:
  - invalid, or
  - ALU or MEM with no remaining free slot of its class, or
  - TERM with the terminator slot not free.
- NOP: consumed without a slot; it does not stop the scan.
- Slot allocation: the k-th consumed ALU (MEM) op goes to the k-th lowest-indexed free ALU (MEM) slot.
- A consumed TERM loads the terminator slot. Lanes after it are not consumed this cycle, and the state moves to WAIT_TERM.
- States:
  - RUN: scan enabled.
  - WAIT_TERM: instr_used = 0; already-filled slots still drain.
  - WAIT_TERM -> RUN on term_resolved. Dispatch resumes the following cycle.
  - term_resolved in RUN is ignored.
- Slot register update: loaded if written; else cleared if transferred; else held. A slot may transfer and reload in the same cycle.
- flush (and rst):
  - All slot valids clear and state becomes RUN next cycle.
  - instr_used = 0 in the flush cycle.
  - Priority: rst > flush > term_resolved > normal update.
  - Sinks must ignore valid in the flush cycle.
- Reset values: all *_valid = 0, all *_out = 0, waiting = 0, state RUN. instr_used = 0 while rst is high.

## Timing
- Latency is 1 cycle: lane consumed in cycle N gives slot valid in N+1.
- instr_used depends combinationally on instr_valid, instr_in, *_valid, *_ready, state, flush and rst. There is no combinational path from instr_in to any *_valid or *_out.
- A full slot whose sink is ready can accept a new op in the same cycle, so throughput is one op per slot per cycle.
- A full fetch group of ALU-only ops with ALU_PORTS = 2 consumes 2 lanes per cycle.
- Minimum terminator-to-next-dispatch gap is 2 cycles: load in N, term_resolved in N+1, dispatch in N+2.
- A flush arriving while a terminator waits leaves state RUN and term_valid = 0 next cycle.

## Test plan
- Defaults, all slots empty, all readies high. Lanes = {ALU, MEM, ALU, ALU}, all valid.
  - Cycle N: instr_used = 4'b0111.
  - N+1: alu_valid = 2'b11, holding lanes 0 and 2; mem_valid = 1.
- Lanes = {NOP, NOP, MEM, TERM}, slots empty.
  - Cycle N: instr_used = 4'b1111.
  - N+1: waiting = 1, term_valid = 1.
  - With term_resolved at N+1 and new valid lanes present: instr_used = 0 at N+1, nonzero at N+2.
- mem_valid = 1 with mem_ready = 0, lanes = {MEM, ALU, ALU, ALU}: instr_used = 0. Raising mem_ready gives instr_used = 4'b0011.
- Lanes = {ALU, TERM, ALU, ALU}, slots empty: instr_used = 4'b0011. Lanes 2-3 stay unconsumed through WAIT_TERM.
- Fill all slots, then assert flush with all readies low.
  - Flush cycle: instr_used = 0.
  - Next cycle: all valids = 0, waiting = 0.
  - Repeat with rst instead of flush: same result.
- Lane 1 invalid, lanes 0, 2, 3 = ALU: instr_used = 4'b0001. Lanes 2-3 are not consumed.
